imm_ext_pipe: RTL and testbench
===============================

// Module: imm_ext_pipe
// PURPOSE
//  Parametrised, registered immediate extender for the pipelined MIPS datapath (decode->execute boundary).
//  Extends an IN_W-bit immediate to OUT_W bits in one of several modes selected by EOp.
//  Uses a valid/ready handshake with a 2-entry skid buffer, so an execute-stage stall never drops or duplicates an immediate.
// PARAMETERS
//  IN_W   16  immediate width; must be >= 8
//  OUT_W  32  result width; must be >= IN_W + 2
// PORTS
//  clk        in   1          single clock; all state updates on posedge
//  reset      in   1          synchronous, active-high
//  in_valid   in   1          imm/EOp valid this cycle
//  in_ready   out  1          block accepts the input this cycle
//  imm        in   IN_W       raw immediate
//  EOp        in   EOP_W      mode; EOP_W=2, or 3 when EXT_BYTE_EN is defined
//  out_valid  out  1          ext holds a valid result
//  out_ready  in   1          consumer takes ext this cycle
//  ext        out  OUT_W      extended result
// BEHAVIOUR
//  Modes: 0 zero-ext {0,imm}; 1 sign-ext {imm[IN_W-1] repl,imm}; 2 upper: imm<<(OUT_W-IN_W);
//   3 branch: sign-ext(imm)<<2, truncated to OUT_W bits.
//  Extension is combinational on the input side; the result is stored, never imm/EOp.
//  Handshake: in xfer = in_valid&in_ready; out xfer = out_valid&out_ready. Data must not change while valid&!ready.
//  Latency: 1 cycle. A result accepted at edge N is on ext with out_valid=1 after edge N.
//  States (count of stored results): EMPTY(0), ONE(1), FULL(2: out reg + skid reg).
//   EMPTY: in xfer -> ONE.
//   ONE: in xfer & !out xfer -> FULL (new result to skid); in & out xfer -> ONE (out reg reloads);
//    out xfer only -> EMPTY.
//   FULL: out xfer -> ONE (skid moves to out reg); input not accepted.
//  in_ready = (state != FULL), decoded from registered state only; no comb path from out_ready.
//  out_valid = (state != EMPTY). Order is strictly FIFO.
//  Throughput: 1 result/cycle while out_ready=1.
//  Reset (sync, dominates all): state=EMPTY, out_valid=0, ext=0, skid=0, in_ready=1 from the first cycle after reset.
//   A reset during FULL discards both entries.
//  in_valid during reset is ignored.
// CONFIGURATION
//  `define EXT_BYTE_EN: EOP_W=3 and extra modes:
//   4 sign-ext imm[7:0]; 5 zero-ext imm[7:0]; 6,7 reserved -> ext=0, still handshaked.
//  Without it: EOP_W=2, only modes 0-3 exist.
// STRUCTURE
//  ext_pkg: EOp encodings (EXT_ZERO, EXT_SIGN, EXT_UPPER, EXT_BRANCH, EXT_SB, EXT_ZB), EOP_W, state encodings.
//  Sub-module ext_skid_buf #(W): generic 2-entry valid/ready skid buffer.
//   imm_ext_pipe = comb extend function + one ext_skid_buf #(OUT_W).
// TESTING
//  1 imm=16'hf000, EOp=1, out_ready=1 -> next cycle ext=32'hfffff000, out_valid=1.
//  2 imm=16'hf000: EOp=0 -> 32'h0000f000; EOp=2 -> 32'hf0000000; EOp=3 -> 32'hffffc000.
//  3 Back-to-back 0x0001,0x8000,0x7fff (EOp=1), out_ready=1 -> 1/cycle:
//    32'h00000001, 32'hffff8000, 32'h00007fff.
//  4 out_ready=0, send 0x0004 then 0x0005 (EOp=0) -> in_ready=0 after the 2nd;
//    a 3rd input is held off. Raise out_ready -> 0x4, 0x5, 0x6 in order, no loss or duplicate.
//  5 Reset asserted in FULL -> next cycle out_valid=0, ext=0, in_ready=1; the old entries never appear.
//  6 EXT_BYTE_EN: imm=16'h1280, EOp=4 -> 32'hffffff80; EOp=5 -> 32'h00000080; EOp=6 -> 32'h0.

Source files
------------

// File: rtl/ext_pkg.sv
// ext_pkg: EOp encodings, EOp width and skid-buffer state encodings for imm_ext_pipe.
// EXT_BYTE_EN widens EOp to 3 bits and adds the byte modes.
package ext_pkg;
`ifdef EXT_BYTE_EN
    localparam int EOP_W = 3;
`else
    localparam int EOP_W = 2;
`endif
    localparam logic [EOP_W-1:0] EXT_ZERO   = EOP_W'(0);
    localparam logic [EOP_W-1:0] EXT_SIGN   = EOP_W'(1);
    localparam logic [EOP_W-1:0] EXT_UPPER  = EOP_W'(2);
    localparam logic [EOP_W-1:0] EXT_BRANCH = EOP_W'(3);
`ifdef EXT_BYTE_EN
    localparam logic [EOP_W-1:0] EXT_SB     = EOP_W'(4);
    localparam logic [EOP_W-1:0] EXT_ZB     = EOP_W'(5);
`endif
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;
endpackage

// File: rtl/ext_skid_buf.sv
// ext_skid_buf: generic 2-entry valid/ready skid buffer; in_ready depends on registered state only.
module ext_skid_buf
    import ext_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    state_t state, state_n;
    logic [W-1:0] out_q, skid_q;
    logic load_out, load_skid, from_skid, in_x, out_x;

    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = out_q;
    assign in_x      = in_valid & in_ready;
    assign out_x     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_EMPTY;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            state <= state_n;
            if (load_out) out_q <= from_skid ? skid_q : in_data;
            if (load_skid) skid_q <= in_data;
        end
    end

    always_comb begin
        state_n   = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        from_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                load_out = in_x;
                state_n  = in_x ? ST_ONE : ST_EMPTY;
            end
            ST_ONE: begin
                load_out  = in_x & out_x;
                load_skid = in_x & !out_x;
                state_n   = in_x ? (out_x ? ST_ONE : ST_FULL) : (out_x ? ST_EMPTY : ST_ONE);
            end
            ST_FULL: begin
                // skid entry advances into the output register
                load_out  = out_x;
                from_skid = out_x;
                state_n   = out_x ? ST_ONE : ST_FULL;
            end
            default: state_n = ST_EMPTY;
        endcase
    end
endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate extender with valid/ready skid buffer.
// Define EXT_BYTE_EN for the byte sign/zero extension modes (EOp 4,5; 6,7 give 0).
module imm_ext_pipe
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  imm,
    input  logic [EOP_W-1:0] EOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] ext
);
    logic [OUT_W-1:0] sext, ext_c;

    assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

    always_comb begin
        ext_c = '0;
        case (EOp)
            EXT_ZERO:   ext_c = {{(OUT_W-IN_W){1'b0}}, imm};
            EXT_SIGN:   ext_c = sext;
            EXT_UPPER:  ext_c = {imm, {(OUT_W-IN_W){1'b0}}};
            EXT_BRANCH: ext_c = {sext[OUT_W-3:0], 2'b00};
`ifdef EXT_BYTE_EN
            EXT_SB:     ext_c = {{(OUT_W-8){imm[7]}}, imm[7:0]};
            EXT_ZB:     ext_c = {{(OUT_W-8){1'b0}}, imm[7:0]};
`endif
            default:    ext_c = '0;
        endcase
    end

    ext_skid_buf #(.W(OUT_W)) u_buf (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(ext_c),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(ext)
    );
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed self-checking bench for imm_ext_pipe.
module tb_imm_ext_pipe;
    import ext_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      imm;
    logic [EOP_W-1:0] eop;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      ext;
    int n_cmp = 0;
    int n_err = 0;

    imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .imm(imm),
        .EOp(eop),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ext(ext)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; imm = 16'h1234; eop = EXT_ZERO; out_ready = 1'b0;
        step();
        step();
        reset = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        n_cmp++;
        if (ext !== 32'h0) begin n_err++; $display("FAIL reset_ext got %h want 00000000", ext); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_modes();
        logic [EOP_W-1:0] m [4];
        logic [31:0] want [4];
        m[0] = EXT_SIGN;   want[0] = 32'hfffff000;
        m[1] = EXT_ZERO;   want[1] = 32'h0000f000;
        m[2] = EXT_UPPER;  want[2] = 32'hf0000000;
        m[3] = EXT_BRANCH; want[3] = 32'hffffc000;
        out_ready = 1'b1; imm = 16'hf000; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eop = m[i];
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || ext !== want[i])
                begin n_err++; $display("FAIL mode%0d got v=%0b %h want v=1 %h", i, out_valid, ext, want[i]); end
        end
        in_valid = 1'b0;
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL modes_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v [3];
        logic [31:0] want [3];
        v[0] = 16'h0001; want[0] = 32'h00000001;
        v[1] = 16'h8000; want[1] = 32'hffff8000;
        v[2] = 16'h7fff; want[2] = 32'h00007fff;
        out_ready = 1'b1; eop = EXT_SIGN; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imm = v[i];
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || ext !== want[i] || in_ready !== 1'b1)
                begin n_err++; $display("FAIL b2b%0d got v=%0b r=%0b %h want v=1 r=1 %h", i, out_valid, in_ready, ext, want[i]); end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_stall();
        out_ready = 1'b0; eop = EXT_ZERO; in_valid = 1'b1; imm = 16'h0004;
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || ext !== 32'h4 || in_ready !== 1'b1)
            begin n_err++; $display("FAIL stall_first got v=%0b r=%0b %h want v=1 r=1 4", out_valid, in_ready, ext); end
        imm = 16'h0005;
        step();
        n_cmp++;
        if (in_ready !== 1'b0 || ext !== 32'h4)
            begin n_err++; $display("FAIL stall_full got r=%0b %h want r=0 4", in_ready, ext); end
        imm = 16'h0006;
        step();
        n_cmp++;
        if (in_ready !== 1'b0 || ext !== 32'h4 || out_valid !== 1'b1)
            begin n_err++; $display("FAIL stall_hold got v=%0b r=%0b %h want v=1 r=0 4", out_valid, in_ready, ext); end
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (ext !== 32'h5 || out_valid !== 1'b1 || in_ready !== 1'b1)
            begin n_err++; $display("FAIL stall_second got v=%0b r=%0b %h want v=1 r=1 5", out_valid, in_ready, ext); end
        step();
        n_cmp++;
        if (ext !== 32'h6 || out_valid !== 1'b1)
            begin n_err++; $display("FAIL stall_third got v=%0b %h want v=1 6", out_valid, ext); end
        in_valid = 1'b0;
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0; eop = EXT_ZERO; in_valid = 1'b1; imm = 16'h0011;
        step();
        imm = 16'h0022;
        step();
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL rfull_ready got %0b want 0", in_ready); end
        reset = 1'b1; imm = 16'h0099;
        step();
        reset = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || ext !== 32'h0 || in_ready !== 1'b1)
            begin n_err++; $display("FAIL rfull_clear got v=%0b r=%0b %h want v=0 r=1 0", out_valid, in_ready, ext); end
        in_valid = 1'b1; imm = 16'h0033;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || ext !== 32'h33)
            begin n_err++; $display("FAIL rfull_new got v=%0b %h want v=1 33", out_valid, ext); end
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rfull_stale got v=%0b %h want v=0", out_valid, ext); end
    endtask

`ifdef EXT_BYTE_EN
    task automatic test_byte();
        logic [EOP_W-1:0] m [4];
        logic [31:0] want [4];
        m[0] = EXT_SB;     want[0] = 32'hffffff80;
        m[1] = EXT_ZB;     want[1] = 32'h00000080;
        m[2] = EOP_W'(6);  want[2] = 32'h0;
        m[3] = EOP_W'(7);  want[3] = 32'h0;
        out_ready = 1'b1; imm = 16'h1280; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eop = m[i];
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || ext !== want[i])
                begin n_err++; $display("FAIL byte%0d got v=%0b %h want v=1 %h", i, out_valid, ext, want[i]); end
        end
        in_valid = 1'b0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_stall();
        test_reset_full();
`ifdef EXT_BYTE_EN
        test_byte();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
